rsdec_syn: RTL and testbench
============================

# rsdec_syn

Syndrome calculator for the RS(255,223) decoder over GF(2^8), placed directly upstream of the Berlekamp stage. It accepts one received codeword byte per valid cycle, evaluates the received polynomial at the 32 generator roots with Horner's rule, and presents a registered, held bank of 32 syndromes. It also presents a one-cycle completion pulse and status flags that gate the Berlekamp/Chien/Forney pipeline.

## Interface
- `N`, 255, codeword length in bytes (1..255); used by the length check.
- `clk`  input  1  rising-edge clock.
- `clr`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  `in_data`/`in_last` carry a byte this cycle.
- `in_data`  input  8  received byte; the first byte of a frame is coefficient r_(N-1), i.e. the highest degree.
- `in_last`  input  1  final byte of the frame; qualified by `in_valid`.
- `syndrome0` … `syndrome31`  output  8 each  S_i = r(alpha^i); held until the next frame completes.
- `syn_valid`  output  1  one-cycle pulse: a new syndrome bank is on the outputs.
- `syn_nz`  output  1  at least one syndrome in the current bank is nonzero (errors present); held with the bank.
- `len_err`  output  1  frame length was not N; held with the bank (see Configuration).

One clock; reset is synchronous and active-high.

## Operation
- Field arithmetic:
  - GF(2^8), primitive polynomial x^8+x^7+x^2+x+1 (0x187), alpha = 0x02.
  - Addition is XOR.
  - Each lane i multiplies by the constant alpha^i; lane 0 is a pass-through.
- Two register banks:
  - Accumulator bank acc0..acc31, internal.
  - Output bank syndrome0..31.
- Per-frame flag `first`:
  - Set by reset.
  - Set after every accepted `in_last`.
  - Cleared by any other accepted byte.
- Accepted byte with `first` = 1: acc_i <= in_data for all i. The byte count loads 1.
- Accepted byte with `first` = 0: acc_i <= acc_i·alpha^i ^ in_data. The byte count increments.
- Accepted byte with `in_last` = 1:
  - Output bank <= the values acc_i would take this cycle, using the same update rule. A 1-byte frame gives syndrome_i = in_data.
  - `syn_nz` <= OR of those 32 values ≠ 0.
  - `len_err` updates.
  - `syn_valid` <= 1.
  - Accumulators are then don't-care; `first` <= 1.
- `in_valid` = 0: accumulators, count and `first` hold. Gaps inside a frame are legal.
- Output bank changes only on frame completion. Berlekamp reads it for its full run while the next frame accumulates. A new completion overwrites the bank regardless of downstream state; no backpressure exists.
- Byte counter: 8 bits, saturating at 255, with a sticky overflow bit set when an accepted non-first byte arrives at count = N.

## Timing
- Reset: all accumulators and outputs 0; `syn_valid` = 0, `syn_nz` = 0, `len_err` = 0, `first` = 1, count = 0.
- Reset in mid-frame discards the partial frame. The next accepted byte is a first byte.
- Throughput: one byte per cycle, sustained.
- Back-to-back frames: `in_last` at cycle t and the next frame's first byte at t+1 are legal.
- Latency: `in_valid`&`in_last` sampled at edge t → syndromes, `syn_nz` and `len_err` valid and `syn_valid` = 1 after edge t.
  - `syn_valid` drops after edge t+1 unless another `in_last` is accepted at t+1.
  - A one-byte frame at t+1 gives a second consecutive pulse.
- `clr` and `in_valid` in the same cycle: reset wins and the byte is dropped.

## Configuration
- `RSDEC_SYN_LENCHK_EN` defined:
  - Byte counter and overflow logic are built.
  - `len_err` <= (final count ≠ N) OR overflow, including the last byte.
  - A 1-byte frame with N = 255 sets `len_err`.
- Not defined:
  - Counter logic is omitted.
  - `len_err` is tied to 0.
  - Frames of any length produce syndromes normally.

## Test plan
- Reset, then 255 bytes of 0x00 with `in_last` on byte 255 → all syndromes 0x00, `syn_nz` = 0, `len_err` = 0, `syn_valid` pulses one cycle after the last byte.
- 254 × 0x00, then 0x01 as last byte (error at r_0) → all syndromes 0x01, `syn_nz` = 1.
- 0x01 as first byte, then 254 × 0x00 (error at r_254) → syndrome0 = 0x01, syndrome1 = 0xC3 (alpha^-1).
- Same stream with random `in_valid` gaps → identical results; outputs stay constant between pulses.
- Back-to-back frames (all-zero, then single error) → two pulses 255 cycles apart. The first bank holds until the second pulse.
- `clr` at byte 100 then a clean full all-zero frame → zero syndromes.
- With `RSDEC_SYN_LENCHK_EN`, a 254-byte frame → `len_err` = 1.

Source files
------------

// File: rtl/rsdec_syn.sv
// rtl/rsdec_syn.sv - RS(255,223) syndrome calculator, 32 Horner lanes over GF(2^8); optional length check under RSDEC_SYN_LENCHK_EN
module rsdec_syn #(
   parameter int N = 255
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic [7:0] syndrome0,
   output logic [7:0] syndrome1,
   output logic [7:0] syndrome2,
   output logic [7:0] syndrome3,
   output logic [7:0] syndrome4,
   output logic [7:0] syndrome5,
   output logic [7:0] syndrome6,
   output logic [7:0] syndrome7,
   output logic [7:0] syndrome8,
   output logic [7:0] syndrome9,
   output logic [7:0] syndrome10,
   output logic [7:0] syndrome11,
   output logic [7:0] syndrome12,
   output logic [7:0] syndrome13,
   output logic [7:0] syndrome14,
   output logic [7:0] syndrome15,
   output logic [7:0] syndrome16,
   output logic [7:0] syndrome17,
   output logic [7:0] syndrome18,
   output logic [7:0] syndrome19,
   output logic [7:0] syndrome20,
   output logic [7:0] syndrome21,
   output logic [7:0] syndrome22,
   output logic [7:0] syndrome23,
   output logic [7:0] syndrome24,
   output logic [7:0] syndrome25,
   output logic [7:0] syndrome26,
   output logic [7:0] syndrome27,
   output logic [7:0] syndrome28,
   output logic [7:0] syndrome29,
   output logic [7:0] syndrome30,
   output logic [7:0] syndrome31,
   output logic       syn_valid,
   output logic       syn_nz,
   output logic       len_err
);

   // multiply by x modulo x^8+x^7+x^2+x+1
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h87 : 8'h00);
   endfunction

   // general product; with a constant operand this folds to an XOR network
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = gf_xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] alpha_pow(input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 0; k < n; k++) r = gf_xtime(r);
      return r;
   endfunction

   logic [7:0] r_acc [32];
   logic [7:0] r_syn [32];
   logic [7:0] w_next [32];
   logic       r_first;
   logic       r_valid;
   logic       r_nz;
   logic       w_nz;

   // Horner step per lane: a first byte restarts the polynomial, later bytes fold in
   for (genvar g = 0; g < 32; g++) begin : g_lane
      localparam logic [7:0] C_ROOT = alpha_pow(g);
      assign w_next[g] = r_first ? in_data : (gf_mul(r_acc[g], C_ROOT) ^ in_data);
   end

   // errors present when any of the completing syndromes is nonzero
   always_comb begin
      w_nz = 1'b0;
      for (int i = 0; i < 32; i++) w_nz = w_nz | (|w_next[i]);
   end

   // accumulate accepted bytes; on the last byte capture the bank and pulse syn_valid
   always_ff @(posedge clk) begin
      if (clr) begin
         r_first <= 1'b1;
         r_valid <= 1'b0;
         r_nz    <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            r_acc[i] <= 8'h00;
            r_syn[i] <= 8'h00;
         end
      end else begin
         r_valid <= 1'b0;
         if (in_valid) begin
            for (int i = 0; i < 32; i++) r_acc[i] <= w_next[i];
            if (in_last) begin
               for (int i = 0; i < 32; i++) r_syn[i] <= w_next[i];
               r_nz    <= w_nz;
               r_valid <= 1'b1;
               r_first <= 1'b1;
            end else begin
               r_first <= 1'b0;
            end
         end
      end
   end

`ifdef RSDEC_SYN_LENCHK_EN
   localparam logic [7:0] C_N = 8'(N);

   logic [7:0] r_cnt;
   logic       r_ovf;
   logic       r_len_err;
   logic [7:0] w_cnt_next;
   logic       w_ovf_next;

   // count including the current byte; overflow marks a byte arriving past N
   always_comb begin
      w_cnt_next = 8'd1;
      w_ovf_next = 1'b0;
      if (!r_first) begin
         w_cnt_next = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
         w_ovf_next = r_ovf | (r_cnt == C_N);
      end
   end

   // track frame length and latch the verdict with the syndrome bank
   always_ff @(posedge clk) begin
      if (clr) begin
         r_cnt     <= 8'd0;
         r_ovf     <= 1'b0;
         r_len_err <= 1'b0;
      end else if (in_valid) begin
         r_cnt <= w_cnt_next;
         r_ovf <= w_ovf_next;
         if (in_last) r_len_err <= (w_cnt_next != C_N) | w_ovf_next;
      end
   end

   assign len_err = r_len_err;
`else
   assign len_err = 1'b0;
`endif

   assign syn_valid  = r_valid;
   assign syn_nz     = r_nz;
   assign syndrome0  = r_syn[0];
   assign syndrome1  = r_syn[1];
   assign syndrome2  = r_syn[2];
   assign syndrome3  = r_syn[3];
   assign syndrome4  = r_syn[4];
   assign syndrome5  = r_syn[5];
   assign syndrome6  = r_syn[6];
   assign syndrome7  = r_syn[7];
   assign syndrome8  = r_syn[8];
   assign syndrome9  = r_syn[9];
   assign syndrome10 = r_syn[10];
   assign syndrome11 = r_syn[11];
   assign syndrome12 = r_syn[12];
   assign syndrome13 = r_syn[13];
   assign syndrome14 = r_syn[14];
   assign syndrome15 = r_syn[15];
   assign syndrome16 = r_syn[16];
   assign syndrome17 = r_syn[17];
   assign syndrome18 = r_syn[18];
   assign syndrome19 = r_syn[19];
   assign syndrome20 = r_syn[20];
   assign syndrome21 = r_syn[21];
   assign syndrome22 = r_syn[22];
   assign syndrome23 = r_syn[23];
   assign syndrome24 = r_syn[24];
   assign syndrome25 = r_syn[25];
   assign syndrome26 = r_syn[26];
   assign syndrome27 = r_syn[27];
   assign syndrome28 = r_syn[28];
   assign syndrome29 = r_syn[29];
   assign syndrome30 = r_syn[30];
   assign syndrome31 = r_syn[31];

endmodule

// File: tb/tb_rsdec_syn.sv
// tb/tb_rsdec_syn.sv - directed vector bench for rsdec_syn
module tb_rsdec_syn;
   localparam int N = 255;
`ifdef RSDEC_SYN_LENCHK_EN
   localparam bit LENCHK = 1'b1;
`else
   localparam bit LENCHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic [7:0] syn [32];
   logic       syn_valid;
   logic       syn_nz;
   logic       len_err;

   always #5 clk = ~clk;

   rsdec_syn #(.N(N)) dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .syndrome0(syn[0]),   .syndrome1(syn[1]),   .syndrome2(syn[2]),   .syndrome3(syn[3]),
      .syndrome4(syn[4]),   .syndrome5(syn[5]),   .syndrome6(syn[6]),   .syndrome7(syn[7]),
      .syndrome8(syn[8]),   .syndrome9(syn[9]),   .syndrome10(syn[10]), .syndrome11(syn[11]),
      .syndrome12(syn[12]), .syndrome13(syn[13]), .syndrome14(syn[14]), .syndrome15(syn[15]),
      .syndrome16(syn[16]), .syndrome17(syn[17]), .syndrome18(syn[18]), .syndrome19(syn[19]),
      .syndrome20(syn[20]), .syndrome21(syn[21]), .syndrome22(syn[22]), .syndrome23(syn[23]),
      .syndrome24(syn[24]), .syndrome25(syn[25]), .syndrome26(syn[26]), .syndrome27(syn[27]),
      .syndrome28(syn[28]), .syndrome29(syn[29]), .syndrome30(syn[30]), .syndrome31(syn[31]),
      .syn_valid(syn_valid), .syn_nz(syn_nz), .len_err(len_err)
   );

   typedef struct {
      int         len;
      int         k;
      logic [7:0] e;
      bit         gaps;
      logic [7:0] s0;
      logic [7:0] s1;
      logic [7:0] s2;
   } vec_t;

   vec_t       tbl [10];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] pw [255];
   int         lg [256];
   logic [7:0] snap [32];
   int         hold_chg;
   int         pulses;
   logic       first_sv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // single error of value e at coefficient k: S_i = e * alpha^(k*i)
   function automatic logic [7:0] term(input int k, input logic [7:0] e, input int i);
      if (k < 0 || e == 8'h00) return 8'h00;
      return pw[(lg[e] + (k * i) % 255) % 255];
   endfunction

   task automatic step(input logic v, input logic [7:0] d, input logic l, input bit is_first);
      @(negedge clk);
      if (is_first) begin
         first_sv = syn_valid;
         for (int i = 0; i < 32; i++) snap[i] = syn[i];
         hold_chg = 0;
         pulses   = 0;
      end else begin
         pulses += int'(syn_valid);
         for (int i = 0; i < 32; i++) if (syn[i] !== snap[i]) hold_chg++;
      end
      in_valid = v;
      in_data  = d;
      in_last  = l;
   endtask

   task automatic send_frame(input int len, input int k, input logic [7:0] e, input bit gaps);
      int         c;
      logic [7:0] d;
      for (int j = 0; j < len; j++) begin
         c = len - 1 - j;
         d = (c == k) ? e : 8'h00;
         if (gaps && j > 0)
            repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom), 1'($urandom), 1'b0);
         step(1'b1, d, (j == len - 1), (j == 0));
      end
   endtask

   task automatic check_bank(input string tag, input int len, input int k, input logic [7:0] e,
                             input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
      int   bad;
      logic nz_exp;
      logic [7:0] x;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk({tag, " syn_valid pulse"}, 32'(syn_valid), 32'd1);
      chk({tag, " syndrome0"}, 32'(syn[0]), 32'(s0));
      chk({tag, " syndrome1"}, 32'(syn[1]), 32'(s1));
      chk({tag, " syndrome2"}, 32'(syn[2]), 32'(s2));
      bad    = 0;
      nz_exp = 1'b0;
      for (int i = 0; i < 32; i++) begin
         x = term(k, e, i);
         if (x != 8'h00) nz_exp = 1'b1;
         if (syn[i] !== x) bad++;
      end
      chk({tag, " lanes wrong"}, 32'(bad), 32'd0);
      chk({tag, " syn_nz"}, 32'(syn_nz), 32'(nz_exp));
      chk({tag, " len_err"}, 32'(len_err), 32'(LENCHK && (len != N)));
      chk({tag, " early pulses"}, 32'(pulses), 32'd0);
      chk({tag, " bank changes mid-frame"}, 32'(hold_chg), 32'd0);
      @(negedge clk);
      chk({tag, " syn_valid drop"}, 32'(syn_valid), 32'd0);
   endtask

   initial begin
      int bad;
      pw[0] = 8'h01;
      lg[1] = 0;
      for (int n = 1; n < 255; n++) begin
         pw[n] = {pw[n-1][6:0], 1'b0} ^ (pw[n-1][7] ? 8'h87 : 8'h00);
         lg[pw[n]] = n;
      end

      tbl[0] = '{255,  -1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[1] = '{255,   0, 8'h01, 1'b0, 8'h01, 8'h01, 8'h01};
      tbl[2] = '{255, 254, 8'h01, 1'b0, 8'h01, 8'hC3, 8'hA2};
      tbl[3] = '{255, 254, 8'h01, 1'b1, 8'h01, 8'hC3, 8'hA2};
      tbl[4] = '{255,   1, 8'h01, 1'b0, 8'h01, 8'h02, 8'h04};
      tbl[5] = '{255,   0, 8'h5A, 1'b1, 8'h5A, 8'h5A, 8'h5A};
      tbl[6] = '{  1,   0, 8'h37, 1'b0, 8'h37, 8'h37, 8'h37};
      tbl[7] = '{254,  -1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[8] = '{256,  -1, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00};
      tbl[9] = '{256, 255, 8'h01, 1'b0, 8'h01, 8'h01, 8'h01};

      // reset asserted together with a valid last byte: the byte must be dropped
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_last  = 1'b1;
      repeat (3) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 32; i++) if (syn[i] !== 8'h00) bad++;
      chk("reset lanes nonzero", 32'(bad), 32'd0);
      chk("reset syn_valid", 32'(syn_valid), 32'd0);
      chk("reset syn_nz", 32'(syn_nz), 32'd0);
      chk("reset len_err", 32'(len_err), 32'd0);
      clr      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;

      for (int v = 0; v < 10; v++) begin
         send_frame(tbl[v].len, tbl[v].k, tbl[v].e, tbl[v].gaps);
         check_bank($sformatf("vec%0d", v), tbl[v].len, tbl[v].k, tbl[v].e,
                    tbl[v].s0, tbl[v].s1, tbl[v].s2);
      end

      // back-to-back: all-zero frame, single-error frame, then a one-byte frame
      send_frame(255, -1, 8'h00, 1'b0);
      send_frame(255, 254, 8'h01, 1'b0);
      chk("b2b first pulse", 32'(first_sv), 32'd1);
      bad = 0;
      for (int i = 0; i < 32; i++) if (snap[i] !== 8'h00) bad++;
      chk("b2b first bank lanes", 32'(bad), 32'd0);
      send_frame(1, 0, 8'h9C, 1'b0);
      chk("b2b second pulse", 32'(first_sv), 32'd1);
      bad = 0;
      for (int i = 0; i < 32; i++) if (snap[i] !== term(254, 8'h01, i)) bad++;
      chk("b2b second bank lanes", 32'(bad), 32'd0);
      check_bank("b2b one-byte", 1, 0, 8'h9C, 8'h9C, 8'h9C, 8'h9C);

      // reset in mid-frame discards the partial frame and the output bank
      send_frame(255, 3, 8'h11, 1'b0);
      check_bank("pre-clr", 255, 3, 8'h11, 8'h11, term(3, 8'h11, 1), term(3, 8'h11, 2));
      for (int j = 0; j < 100; j++) step(1'b1, 8'hFF, 1'b0, (j == 0));
      @(negedge clk);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      in_last  = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      bad = 0;
      for (int i = 0; i < 32; i++) if (syn[i] !== 8'h00) bad++;
      chk("clr bank cleared", 32'(bad), 32'd0);
      chk("clr syn_valid", 32'(syn_valid), 32'd0);
      send_frame(255, -1, 8'h00, 1'b0);
      check_bank("post-clr", 255, -1, 8'h00, 8'h00, 8'h00, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
